// File: rtl/gate_checker.sv
// gate_checker: on-chip response checker for NAND-derived AND/OR/NOT gates.
// Define GATE_CHK_FAILCAP_EN to build first-failure capture (fail_vec/fail_bits).
module gate_checker #(
  parameter int SETTLE = 2,
  parameter int ERR_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a_o,
  output logic             b_o,
  input  logic             and_i,
  input  logic             or_i,
  input  logic             not_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       fail_vec,
  output logic [2:0]       fail_bits
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = (SETTLE > 0) ? CNT_W'(SETTLE - 1) : '0;

  typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [1:0]       vec;
  logic [CNT_W-1:0] settle_cnt;
  logic [2:0]       mismatch;
  logic             start_ok;

  assign start_ok = start && ((state == IDLE) || (state == DONE));
  assign mismatch = {and_i ^ (a_o & b_o), or_i ^ (a_o | b_o), not_i ^ ~a_o};

  assign busy = (state == DRIVE) || (state == WAIT) || (state == CHECK);
  assign done = (state == DONE);
  assign pass = done && (err_cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start_ok) state_next = DRIVE;
      DRIVE:      state_next = (SETTLE > 0) ? WAIT : CHECK;
      WAIT:       if (settle_cnt == '0) state_next = CHECK;
      CHECK:      state_next = (vec == 2'd3) ? DONE : DRIVE;
      default:    state_next = IDLE;
    endcase
  end

  // The counter is preloaded with SETTLE-1 so WAIT lasts exactly SETTLE cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_o        <= 1'b0;
      b_o        <= 1'b0;
      vec        <= 2'd0;
      settle_cnt <= '0;
      err_cnt    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            vec     <= 2'd0;
            err_cnt <= '0;
          end
        end
        DRIVE: begin
          a_o        <= vec[1];
          b_o        <= vec[0];
          settle_cnt <= SETTLE_LOAD;
        end
        WAIT: begin
          if (settle_cnt != '0) settle_cnt <= settle_cnt - CNT_W'(1);
        end
        CHECK: begin
          if ((|mismatch) && (err_cnt != '1)) err_cnt <= err_cnt + ERR_W'(1);
          if (vec != 2'd3) vec <= vec + 2'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef GATE_CHK_FAILCAP_EN
  // err_cnt is still zero only until the first mismatch of the run lands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fail_vec  <= 2'd0;
      fail_bits <= 3'd0;
    end else if (start_ok) begin
      fail_vec  <= 2'd0;
      fail_bits <= 3'd0;
    end else if ((state == CHECK) && (|mismatch) && (err_cnt == '0)) begin
      fail_vec  <= {a_o, b_o};
      fail_bits <= mismatch;
    end
  end
`else
  assign fail_vec  = 2'd0;
  assign fail_bits = 3'd0;
`endif

endmodule

// File: tb/tb_gate_checker.sv
// tb_gate_checker: randomized self-checking bench for gate_checker, with a
// fault-table gate model and a per-run reference of the expected results.
module tb_gate_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] start_v;
  logic [2:0] fault_tab [4];
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;

  logic       a0, b0, and0, or0, not0, busy0, done0, pass0;
  logic [3:0] err0;
  logic [1:0] fv0;
  logic [2:0] fb0;
  logic       a1, b1, and1, or1, not1, busy1, done1, pass1;
  logic [0:0] err1;
  logic [1:0] fv1;
  logic [2:0] fb1;
  logic       a2, b2, and2, or2, not2, busy2, done2, pass2;
  logic [3:0] err2;
  logic [1:0] fv2;
  logic [2:0] fb2;

  // Gate under test: correct gate outputs with per-vector injected bit flips.
  assign and0 = (a0 & b0) ^ fault_tab[{a0, b0}][2];
  assign or0  = (a0 | b0) ^ fault_tab[{a0, b0}][1];
  assign not0 = ~a0 ^ fault_tab[{a0, b0}][0];
  assign and1 = (a1 & b1) ^ fault_tab[{a1, b1}][2];
  assign or1  = (a1 | b1) ^ fault_tab[{a1, b1}][1];
  assign not1 = ~a1 ^ fault_tab[{a1, b1}][0];
  assign and2 = (a2 & b2) ^ fault_tab[{a2, b2}][2];
  assign or2  = (a2 | b2) ^ fault_tab[{a2, b2}][1];
  assign not2 = ~a2 ^ fault_tab[{a2, b2}][0];

  gate_checker #(.SETTLE(2), .ERR_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a_o(a0), .b_o(b0),
    .and_i(and0), .or_i(or0), .not_i(not0), .busy(busy0), .done(done0),
    .pass(pass0), .err_cnt(err0), .fail_vec(fv0), .fail_bits(fb0)
  );

  gate_checker #(.SETTLE(2), .ERR_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a_o(a1), .b_o(b1),
    .and_i(and1), .or_i(or1), .not_i(not1), .busy(busy1), .done(done1),
    .pass(pass1), .err_cnt(err1), .fail_vec(fv1), .fail_bits(fb1)
  );

  gate_checker #(.SETTLE(0), .ERR_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a_o(a2), .b_o(b2),
    .and_i(and2), .or_i(or2), .not_i(not2), .busy(busy2), .done(done2),
    .pass(pass2), .err_cnt(err2), .fail_vec(fv2), .fail_bits(fb2)
  );

  // Snapshot layout: {a,b,busy,done,pass,err[3:0],fail_vec[1:0],fail_bits[2:0]}
  function automatic logic [13:0] snap(input int d);
    case (d)
      0:       return {a0, b0, busy0, done0, pass0, err0, fv0, fb0};
      1:       return {a1, b1, busy1, done1, pass1, 3'b000, err1, fv1, fb1};
      default: return {a2, b2, busy2, done2, pass2, err2, fv2, fb2};
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int d);
    @(negedge clk);
    start_v[d] = 1'b1;
    @(posedge clk);
  endtask

  task automatic setFaults(input logic [2:0] f0, input logic [2:0] f1,
                           input logic [2:0] f2, input logic [2:0] f3);
    fault_tab[0] = f0;
    fault_tab[1] = f1;
    fault_tab[2] = f2;
    fault_tab[3] = f3;
  endtask

  task automatic runCheck(input int d, input int settle, input int err_max,
                          input int restart_at, input int reset_at, input string tag);
    int          nfail;
    int          first;
    int          k;
    int          busy_cycles;
    int          run_len;
    int          exp_err;
    logic [13:0] s;
    logic [1:0]  exp_fv;
    logic [2:0]  exp_fb;

    nfail = 0;
    first = -1;
    for (int v = 0; v < 4; v++) begin
      if (fault_tab[v] != 3'd0) begin
        nfail++;
        if (first < 0) first = v;
      end
    end
    exp_err = (nfail > err_max) ? err_max : nfail;
    exp_fv  = 2'd0;
    exp_fb  = 3'd0;
`ifdef GATE_CHK_FAILCAP_EN
    if (first >= 0) begin
      exp_fv = 2'(first);
      exp_fb = fault_tab[first];
    end
`endif
    run_len     = 4 * (settle + 2);
    busy_cycles = 0;
    k           = 0;

    applyStimulus(d);
    while (k < 200) begin
      @(negedge clk);
      start_v[d] = (k == restart_at);
      if (k == reset_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        start_v[d] = 1'b0;
        s = snap(d);
        checkOutput({tag, "_rst"}, 16'(s), 16'(0));
        rst_n = 1'b1;
        return;
      end
      s = snap(d);
      if (s[10]) break;
      if (s[11]) busy_cycles++;
      for (int v = 0; v < 4; v++) begin
        if (k == v * (settle + 2) + settle + 1)
          checkOutput($sformatf("%s_vec%0d", tag, v), 16'(s[13:12]), 16'(v));
      end
      k++;
    end
    start_v[d] = 1'b0;

    checkOutput({tag, "_len"},  16'(k), 16'(run_len));
    checkOutput({tag, "_busy"}, 16'(busy_cycles), 16'(run_len));
    checkOutput({tag, "_done"}, 16'({s[11], s[10]}), 16'(2'b01));
    checkOutput({tag, "_pass"}, 16'(s[9]), 16'(nfail == 0));
    checkOutput({tag, "_err"},  16'(s[8:5]), 16'(exp_err));
    checkOutput({tag, "_fvec"}, 16'(s[4:3]), 16'(exp_fv));
    checkOutput({tag, "_fbit"}, 16'(s[2:0]), 16'(exp_fb));
    @(negedge clk);
    s = snap(d);
    checkOutput({tag, "_hold"}, 16'({s[13:12], s[10]}), 16'(3'b111));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d;
    rst_n   = 1'b0;
    start_v = 3'b000;
    setFaults(3'd0, 3'd0, 3'd0, 3'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("reset%0d", i), 16'(snap(i)), 16'(0));
    rst_n = 1'b1;

    setFaults(3'd0, 3'd0, 3'd0, 3'd0);
    runCheck(0, 2, 15, -1, -1, "good");

    setFaults(3'd0, 3'b010, 3'b010, 3'b010);
    runCheck(0, 2, 15, -1, -1, "or_stuck");

    setFaults(3'b001, 3'b001, 3'b001, 3'b001);
    runCheck(1, 2, 1, -1, -1, "not_inv_sat");

    setFaults(3'd0, 3'b010, 3'b010, 3'b010);
    runCheck(0, 2, 15, 5, -1, "restart");

    setFaults(3'b100, 3'd0, 3'd0, 3'd0);
    runCheck(0, 2, 15, -1, 7, "midreset");
    setFaults(3'd0, 3'd0, 3'd0, 3'd0);
    runCheck(0, 2, 15, -1, -1, "after_rst");

    runCheck(2, 0, 15, -1, -1, "settle0");

    for (int r = 0; r < 10; r++) begin
      d = int'($urandom_range(0, 2));
      for (int v = 0; v < 4; v++)
        fault_tab[v] = ($urandom_range(0, 1) != 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      runCheck(d, (d == 2) ? 0 : 2, (d == 1) ? 1 : 15, -1, -1, $sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
